// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback requesters,
// with a registered write stage and a pending-write scoreboard for RAW hazard stalls.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*5-1:0]     req_rd_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_wd_i,
  input  logic                     resv_valid_i,
  input  logic [4:0]               resv_rd_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_rd_o,
  output logic [WIDTH-1:0]         rf_wd_o,
  output logic [31:0]              busy_o,
  output logic [2:0]               grant_idx_o
);

  logic [2:0]       ptr_q, ptr_d;
  logic             rf_we_q;
  logic [4:0]       rf_rd_q;
  logic [WIDTH-1:0] rf_wd_q;
  logic [31:0]      busy_q, busy_d;

  logic             found, gnt;
  logic [2:0]       widx, cand_idx;
  int unsigned      cand;
  logic [4:0]       sel_rd;
  logic [WIDTH-1:0] sel_wd;

  // Search from the pointer, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    widx     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[2:0];
      if (!found && req_valid_i[cand_idx]) begin
        found = 1'b1;
        widx  = cand_idx;
      end
    end
  end

  assign gnt         = found & ~rst_i;
  assign grant_idx_o = gnt ? widx : 3'd0;
  assign sel_rd      = req_rd_i[5*widx +: 5];
  assign sel_wd      = req_wd_i[WIDTH*widx +: WIDTH];

  always_comb begin
    req_ready_o = '0;
    if (gnt) req_ready_o[widx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt) ptr_d = (widx == 3'(NUM_REQ - 1)) ? 3'd0 : widx + 3'd1;
  end

  // Set is applied after clear so a fresh reservation of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (gnt && sel_rd != 5'd0) busy_d[sel_rd] = 1'b0;
    if (resv_valid_i && resv_rd_i != 5'd0) busy_d[resv_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      rf_we_q <= gnt && (sel_rd != 5'd0);
      // x0 writes are accepted but dropped, leaving the port's address/data untouched.
      if (gnt && sel_rd != 5'd0) begin
        rf_rd_q <= sel_rd;
        rf_wd_q <= sel_wd;
      end
    end
  end

  assign rf_we_o = rf_we_q;
  assign rf_rd_o = rf_rd_q;
  assign rf_wd_o = rf_wd_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model of the
// round-robin grant order, the one-cycle write stage and the busy scoreboard.
module tb_regfile_wb_arbiter;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*5-1:0]     req_rd;
  logic [NUM_REQ*WIDTH-1:0] req_wd;
  logic                     resv_valid;
  logic [4:0]               resv_rd;
  logic                     rf_we;
  logic [4:0]               rf_rd;
  logic [WIDTH-1:0]         rf_wd;
  logic [31:0]              busy;
  logic [2:0]               grant_idx;

  logic [4:0]       t_rd [NUM_REQ];
  logic [WIDTH-1:0] t_wd [NUM_REQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rd[5*i +: 5]         = t_rd[i];
      req_wd[WIDTH*i +: WIDTH] = t_wd[i];
    end
  end

  regfile_wb_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rd_i     (req_rd),
    .req_wd_i     (req_wd),
    .resv_valid_i (resv_valid),
    .resv_rd_i    (resv_rd),
    .rf_we_o      (rf_we),
    .rf_rd_o      (rf_rd),
    .rf_wd_o      (rf_wd),
    .busy_o       (busy),
    .grant_idx_o  (grant_idx)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  int          m_ptr = 0;
  bit [31:0]   m_busy = '0;
  bit          m_we = 1'b0;
  bit [4:0]    m_rd = '0;
  bit [31:0]   m_wd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a posedge with inputs already set; checks this cycle and the next edge.
  task automatic cycle(output int winner);
    logic [NUM_REQ-1:0] exp_ready;
    #1;
    winner = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (winner < 0 && req_valid[i]) winner = i;
      end
    end
    exp_ready = '0;
    if (winner >= 0) exp_ready[winner] = 1'b1;
    check("ready", 64'(req_ready), 64'(exp_ready));
    if (!rst) check("grant_idx", 64'(grant_idx), 64'(winner < 0 ? 0 : winner));
    if (rst) begin
      m_ptr = 0; m_busy = '0; m_we = 0; m_rd = '0; m_wd = '0;
    end else begin
      m_we = 0;
      if (winner >= 0) begin
        m_ptr = (winner + 1) % NUM_REQ;
        if (t_rd[winner] != 0) begin
          m_we = 1; m_rd = t_rd[winner]; m_wd = t_wd[winner];
          m_busy[t_rd[winner]] = 1'b0;
        end
      end
      if (resv_valid && resv_rd != 0) m_busy[resv_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rf_we", 64'(rf_we), 64'(m_we));
    check("busy", 64'(busy), 64'(m_busy));
    if (m_we) begin
      check("rf_rd", 64'(rf_rd), 64'(m_rd));
      check("rf_wd", 64'(rf_wd), 64'(m_wd));
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; resv_valid = 0; resv_rd = '0;
  endtask

  int w;
  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1; idle_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin t_rd[i] = '0; t_wd[i] = '0; end
    @(posedge clk); #1;

    // Reset with everyone requesting
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) begin t_rd[i] = 5'(5 + i); t_wd[i] = 32'hA0 + i; end
    cycle(w);
    cycle(w);
    check("rst_rd", 64'(rf_rd), 64'd0);
    check("rst_wd", 64'(rf_wd), 64'd0);
    rst = 0;

    // Fairness with all three continuously valid
    for (int n = 0; n < 6; n++) begin
      cycle(w);
      check("rr_order", 64'(w), 64'(exp_seq[n]));
      check("rr_rd", 64'(rf_rd), 64'(5 + exp_seq[n]));
    end

    // Single write latency, then idle hold
    idle_inputs();
    req_valid[1] = 1; t_rd[1] = 5'd10; t_wd[1] = 32'hDEADBEEF;
    cycle(w);
    check("lat_we", 64'(rf_we), 64'd1);
    check("lat_rd", 64'(rf_rd), 64'd10);
    req_valid = '0;
    cycle(w);
    check("idle_we", 64'(rf_we), 64'd0);
    check("idle_rd", 64'(rf_rd), 64'd10);
    check("idle_wd", 64'(rf_wd), 64'hDEADBEEF);

    // Scoreboard set, clear, and simultaneous set+clear
    resv_valid = 1; resv_rd = 5'd12;
    cycle(w);
    check("sb_set", 64'(busy[12]), 64'd1);
    resv_valid = 0; req_valid[0] = 1; t_rd[0] = 5'd12; t_wd[0] = 32'h1234;
    cycle(w);
    check("sb_clr", 64'(busy[12]), 64'd0);
    resv_valid = 1; resv_rd = 5'd12;
    cycle(w);
    check("sb_set_wins", 64'(busy[12]), 64'd1);

    // x0 reservation and x0 write
    idle_inputs(); resv_valid = 1; resv_rd = 5'd0;
    cycle(w);
    check("x0_busy", 64'(busy[0]), 64'd0);
    resv_valid = 0; req_valid[2] = 1; t_rd[2] = 5'd0;
    cycle(w);
    check("x0_accept", 64'(w), 64'd2);
    check("x0_we", 64'(rf_we), 64'd0);

    // Get pointer to 2 via a lone req1 grant, then wrap past req2 to req0, then req1
    idle_inputs(); req_valid[1] = 1; t_rd[1] = 5'd3;
    cycle(w);
    req_valid = 3'b011; t_rd[0] = 5'd4;
    cycle(w);
    check("wrap_req0", 64'(w), 64'd0);
    req_valid = 3'b010;
    cycle(w);
    check("then_req1", 64'(w), 64'd1);

    // Randomized traffic: requesters hold until accepted; occasional reset
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1;
          t_rd[i] = 5'($urandom_range(31, 0));
          if ($urandom_range(7, 0) == 0) t_rd[i] = 5'd0;
          t_wd[i] = $urandom;
        end
      end
      resv_valid = ($urandom_range(2, 0) == 0);
      resv_rd = 5'($urandom_range(31, 0));
      rst = ($urandom_range(59, 0) == 0);
      cycle(w);
      if (w >= 0) req_valid[w] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU, load unit, CSR unit) using round-robin arbitration with a valid/ready handshake.
- Drives the regfile write port (we/rd/wd) from a registered output stage.
- Maintains a 32-bit pending-write scoreboard that issue logic uses to stall on RAW hazards.
- Sits between the execute/memory stages and regfile.

Parameters:
- WIDTH, 32, data width; matches cpu_pkg WIDTH.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  requester i presents a write
- req_ready_o  out  NUM_REQ  requester i's write accepted this cycle
- req_rd_i  in  NUM_REQ*5  destination address, requester i at bits [5i+4:5i]
- req_wd_i  in  NUM_REQ*WIDTH  write data, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
- resv_valid_i  in  1  issue stage reserves a destination register
- resv_rd_i  in  5  register being reserved
- rf_we_o  out  1  to regfile write enable
- rf_rd_o  out  5  to regfile destination address
- rf_wd_o  out  WIDTH  to regfile write data
- busy_o  out  32  scoreboard; bit r=1 means a write to xr is outstanding
- grant_idx_o  out  3  index of the requester granted this cycle (debug/perf)

Behaviour:
- Reset (rst_i=1 at posedge):
  - rf_we_o=0, rf_rd_o=0, rf_wd_o=0, busy_o=0.
  - Round-robin pointer = 0.
  - A reset mid-operation discards any in-flight write; req_ready_o is forced 0 while rst_i=1.
- Arbitration (combinational within the cycle):
  - Search starts at pointer p, wrapping modulo NUM_REQ; the first i with req_valid_i[i]=1 wins.
  - req_ready_o is one-hot for the winner, all zero if no requester is valid.
  - grant_idx_o = winner index; 0 when there is no winner.
  - A handshake completes when valid&ready are both high. Requesters hold valid/rd/wd stable until accepted.
- Pointer update: on a completed grant to index g, p <= (g+1) mod NUM_REQ. p is unchanged when there is no grant.
- Output stage, 1-cycle latency:
  - A grant in cycle N drives the regfile port in cycle N+1: rf_we_o=1, rf_rd_o/rf_wd_o = winner's rd/wd.
  - rf_we_o=0 when there is no grant; rf_rd_o/rf_wd_o hold their last values.
  - Throughput is one write per cycle; there is no backpressure from regfile.
- x0 writes: the handshake is accepted (ready=1), but rf_we_o stays 0 the next cycle and the scoreboard is untouched.
- Scoreboard:
  - Set: resv_valid_i=1 with resv_rd_i≠0 sets busy[resv_rd_i] at the next edge.
  - Clear: a completed grant with rd≠0 clears busy[rd] at the next edge (same edge the output register loads).
  - Simultaneous set and clear of the same register: set wins (busy stays 1; a newer write is outstanding).
  - Set and clear of different registers in the same cycle both take effect.
  - busy_o[0] is always 0.
  - Multiple requesters writing the same rd in one cycle: only the winner is accepted; the losers retry later. The scoreboard clears on the first accepted write (single-outstanding model; issue logic guarantees at most one reservation per register).
- Registered vs combinational outputs: busy_o, rf_* and the pointer are registered. req_ready_o and grant_idx_o are combinational from req_valid_i and the pointer.

Test Plan:
- Reset: assert rst_i with all three requesters valid -> req_ready_o=000 and rf_we_o=0 during reset; after reset, the first grant goes to index 0.
- Round-robin fairness: all three valid continuously, rd=5/6/7, wd=A/B/C -> grants 0,1,2,0,1,2; rf_we_o=1 every cycle from N+1 with rd sequence 5,6,7,5…
- Latency and idle: single req1 rd=10 wd=0xDEADBEEF at cycle N -> at N+1 rf_we_o=1, rf_rd_o=10, rf_wd_o=0xDEADBEEF; at N+2 rf_we_o=0 and rf_rd_o/rf_wd_o unchanged.
- Scoreboard: reserve x12 -> busy_o[12]=1 next cycle; writeback rd=12 -> busy_o[12]=0 after the grant edge. Reserve x12 and grant rd=12 in the same cycle -> busy_o[12] stays 1.
- x0 handling: reserve x0 -> busy_o stays 0; requester writes rd=0 -> ready=1, rf_we_o stays 0 the next cycle.
- Pointer wrap and skip: pointer=2, only req0 and req1 valid -> req0 granted, pointer becomes 1; next cycle req1 is granted.
